// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared types and constants for the SHA3 stream padder
//
// Digest variant enum, per-variant rate tables (16-bit words and bytes),
// SHA3 padding bytes and the padder state enum.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  localparam int BLOCK_BITS  = 1152;
  localparam int BLOCK_BYTES = BLOCK_BITS / 8;

  // Indexed by sha3_mode_e.
  localparam logic [6:0] RATE_WORDS [4] = '{7'd72, 7'd68, 7'd52, 7'd36};
  localparam logic [7:0] RATE_BYTES [4] = '{8'd144, 8'd136, 8'd104, 8'd72};

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_EMIT   = 2'd2,
    ST_PAD    = 2'd3
  } state_e;

endpackage

// File: rtl/sha3_pad_byte_mask.sv
// rtl/sha3_pad_byte_mask.sv - combinational SHA3 pad XOR vector for one rate block
//
// Ports:
//   p_i    : byte position of the first pad byte (message bytes in this block)
//   rb_i   : rate in bytes for the active variant
//   mask_o : XOR vector, 0x06 at byte p_i and 0x80 at byte rb_i-1
//            (0x86 when they coincide); all zero when p_i >= rb_i, since
//            the padding then lands in a following block.
module sha3_pad_byte_mask
  import sha3_pkg::*;
(
  input  logic [7:0]            p_i,
  input  logic [7:0]            rb_i,
  output logic [BLOCK_BITS-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    if (p_i < rb_i) begin
      for (int k = 0; k < BLOCK_BYTES; k++) begin
        if (8'(k) == p_i) begin
          mask_o[8*k +: 8] = mask_o[8*k +: 8] ^ PAD_DOMAIN;
        end
        if (8'(k) == rb_i - 8'd1) begin
          mask_o[8*k +: 8] = mask_o[8*k +: 8] ^ PAD_FINAL;
        end
      end
    end
  end

endmodule

// File: rtl/sha3_stream_padder.sv
// rtl/sha3_stream_padder.sv - packs a 16-bit message stream into padded SHA3 rate blocks
//
// Optional feature macro: SHA3_PADDER_LEN_EN (adds msg_len and a byte counter).
//
// Ports:
//   ACLK, ARESET      : clock, asynchronous active-high reset
//   s_axis_t*         : message stream in ([7:0] is the earlier byte),
//                       tuser selects the variant on the first beat
//   blk_data          : rate block, byte k at [8k+7:8k], zero above the rate
//   blk_mode/blk_last : variant and final-block flag for the block
//   blk_valid/ready   : block handshake towards the absorb logic
//   msg_len           : (SHA3_PADDER_LEN_EN) message length in bytes,
//                       meaningful while blk_valid && blk_last
module sha3_stream_padder
  import sha3_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int RATE_MAX = BLOCK_BITS
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [WIDTH-1:0]    s_axis_tdata,
  input  logic [1:0]          s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic [1:0]          s_axis_tuser,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [RATE_MAX-1:0] blk_data,
  output logic [1:0]          blk_mode,
  output logic                blk_last,
  output logic                blk_valid,
`ifdef SHA3_PADDER_LEN_EN
  output logic [63:0]         msg_len,
`endif
  input  logic                blk_ready
);

  state_e                state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [RATE_MAX-1:0]   buf_q, buf_d;
  sha3_mode_e            mode_q, mode_d;
  logic                  last_q, last_d;
  logic                  pend_q, pend_d;
  logic                  tready_q, tready_d;
  logic                  valid_q, valid_d;
`ifdef SHA3_PADDER_LEN_EN
  logic [63:0]           len_q, len_d;
`endif

  logic                  accept;
  logic [1:0]            keep_eff;
  logic [1:0]            beat_nb;
  logic [15:0]           beat_word;
  sha3_mode_e            cur_mode;
  logic [6:0]            rate_w;
  logic [7:0]            rate_b;
  logic [7:0]            beat_p;
  logic [7:0]            mask_p;
  logic [RATE_MAX-1:0]   pad_mask;

  assign accept   = s_axis_tvalid && tready_q;
  // A short tkeep is only meaningful on the last beat; elsewhere it is
  // treated as a full beat.
  assign keep_eff = s_axis_tlast ? s_axis_tkeep : 2'b11;
  assign beat_nb  = (keep_eff == 2'b11) ? 2'd2 :
                    (keep_eff == 2'b01) ? 2'd1 : 2'd0;
  assign beat_word = {(beat_nb == 2'd2) ? s_axis_tdata[15:8] : 8'h00,
                      (beat_nb != 2'd0) ? s_axis_tdata[7:0]  : 8'h00};
  // The first beat of a message already needs the new variant's rate.
  assign cur_mode = (state_q == ST_IDLE) ? sha3_mode_e'(s_axis_tuser) : mode_q;
  assign rate_w   = RATE_WORDS[cur_mode];
  assign rate_b   = RATE_BYTES[cur_mode];
  assign beat_p   = {cnt_q, 1'b0} + {6'd0, beat_nb};
  // The pad-only block starts its padding at byte 0.
  assign mask_p   = (state_q == ST_PAD) ? 8'd0 : beat_p;

  sha3_pad_byte_mask u_mask (
    .p_i    (mask_p),
    .rb_i   (rate_b),
    .mask_o (pad_mask)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    last_d  = last_q;
    pend_d  = pend_q;
`ifdef SHA3_PADDER_LEN_EN
    len_d   = len_q;
`endif
    case (state_q)
      ST_IDLE, ST_ABSORB: begin
        if (accept) begin
          if (state_q == ST_IDLE) begin
            mode_d = sha3_mode_e'(s_axis_tuser);
`ifdef SHA3_PADDER_LEN_EN
            len_d  = {62'd0, beat_nb};
`endif
          end else begin
`ifdef SHA3_PADDER_LEN_EN
            len_d  = len_q + {62'd0, beat_nb};
`endif
          end
          // Buffer is all-zero above cnt, so a plain write is enough.
          buf_d[{cnt_q, 4'b0000} +: 16] = beat_word;
          cnt_d = cnt_q + 7'd1;
          if (s_axis_tlast) begin
            state_d = ST_EMIT;
            if (beat_p < rate_b) begin
              buf_d  = buf_d ^ pad_mask;
              last_d = 1'b1;
            end else begin
              // Block exactly full: padding goes into an extra block.
              last_d = 1'b0;
              pend_d = 1'b1;
            end
          end else if (cnt_q == rate_w - 7'd1) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          buf_d  = '0;
          cnt_d  = 7'd0;
          last_d = 1'b0;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = ST_PAD;
          end else if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end
      ST_PAD: begin
        buf_d   = buf_q ^ pad_mask;
        last_d  = 1'b1;
        state_d = ST_EMIT;
      end
      default: state_d = ST_IDLE;
    endcase
    tready_d = (state_d == ST_IDLE) || (state_d == ST_ABSORB);
    valid_d  = (state_d == ST_EMIT);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 7'd0;
      buf_q    <= '0;
      mode_q   <= SHA3_224;
      last_q   <= 1'b0;
      pend_q   <= 1'b0;
      tready_q <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SHA3_PADDER_LEN_EN
      len_q    <= 64'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      tready_q <= tready_d;
      valid_q  <= valid_d;
`ifdef SHA3_PADDER_LEN_EN
      len_q    <= len_d;
`endif
    end
  end

  assign s_axis_tready = tready_q;
  assign blk_data      = buf_q;
  assign blk_mode      = mode_q;
  assign blk_last      = last_q;
  assign blk_valid     = valid_q;
`ifdef SHA3_PADDER_LEN_EN
  assign msg_len       = len_q;
`endif

  // A partial beat in the middle of a message is a protocol error.
  a_keep_full: assert property (@(posedge ACLK) disable iff (ARESET)
    (s_axis_tvalid && s_axis_tready && !s_axis_tlast) |-> (s_axis_tkeep == 2'b11));

endmodule
